signal_phase_controller: RTL

- Consumer end of the sensor interface.
- Reads the 8-bit moving averages from the four approach sensors (north, east, south, west).
- Drives the shared next_road select that those sensors sample on.
- Sequences green/yellow/all-red phases, with green length scaled to queue demand.
- Sits between the four sensor blocks and the lamp drivers.

---
 rtl/signal_phase_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/signal_phase_controller.sv
// signal_phase_controller
//   Consumer end of the approach-sensor interface. Reads the four 8-bit
//   moving averages, drives the shared next_road select the sensors sample
//   on, and sequences GREEN -> YELLOW -> ALLRED phases with the green length
//   scaled to the demand of the road being served.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   tick       one-cycle timebase enable; every duration is counted in ticks
//   avg_north  road 0 sensor average
//   avg_east   road 1 sensor average
//   avg_south  road 2 sensor average
//   avg_west   road 3 sensor average
//   next_road  road to be served next (to the sensors)
//   cur_road   road currently holding, or last held, green
//   lights     lamp vector, road r = bits [3r+2:3r] = {red, yellow, green}
//   phase      0 = GREEN, 1 = YELLOW, 2 = ALLRED
//   timer      ticks remaining in the current phase, including this one
//
// phase     | meaning
// ----------+-------------------------------------------------
// PH_GREEN  | cur_road shows green, timer loaded from clamped avg
// PH_YELLOW | cur_road shows yellow, next_road already updated
// PH_ALLRED | every road red (clearance, and the reset state)

module signal_phase_controller #(
  parameter int MIN_GREEN   = 10,
  parameter int MAX_GREEN   = 60,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int SKIP_THRESH = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [7:0]  avg_north,
  input  logic [7:0]  avg_east,
  input  logic [7:0]  avg_south,
  input  logic [7:0]  avg_west,
  output logic [1:0]  next_road,
  output logic [1:0]  cur_road,
  output logic [11:0] lights,
  output logic [1:0]  phase,
  output logic [7:0]  timer
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

  phase_t      phase_q, phase_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  cur_road_q, cur_road_d;
  logic [1:0]  next_road_q, next_road_d;
  logic [11:0] lights_q, lights_d;

  logic [31:0] avg_all;
  assign avg_all = {avg_west, avg_south, avg_east, avg_north};

  function automatic logic [7:0] avg_of(input logic [31:0] all, input logic [1:0] r);
    return all[{r, 3'b000} +: 8];
  endfunction

  // Plain unsigned compare against the limits; avg is never modified.
  function automatic logic [7:0] clamp_green(input logic [7:0] a);
    if (int'(a) < MIN_GREEN)      return 8'(MIN_GREEN);
    else if (int'(a) > MAX_GREEN) return 8'(MAX_GREEN);
    else                          return a;
  endfunction

  // Scan c+1..c+4 (the current road last); first road at or above the
  // threshold wins, otherwise fall back to plain round-robin.
  function automatic logic [1:0] sel_next(input logic [1:0] c, input logic [31:0] all);
    logic [1:0] r;
    logic [1:0] pick;
    logic       found;
    pick  = c + 2'd1;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      r = c + 2'(k);
      if (!found && (int'(avg_of(all, r)) >= SKIP_THRESH)) begin
        pick  = r;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [11:0] decode_lights(input phase_t ph, input logic [1:0] r);
    logic [11:0] l;
    l = ALL_RED;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == r) begin
        if (ph == PH_GREEN)       l[3*i +: 3] = 3'b001;
        else if (ph == PH_YELLOW) l[3*i +: 3] = 3'b010;
      end
    end
    return l;
  endfunction

  always_comb begin
    phase_d     = phase_q;
    timer_d     = timer_q;
    cur_road_d  = cur_road_q;
    next_road_d = next_road_q;
    if (tick) begin
      if (timer_q > 8'd1) begin
        timer_d = timer_q - 8'd1;
      end else begin
        case (phase_q)
          PH_ALLRED: begin
            phase_d    = PH_GREEN;
            cur_road_d = next_road_q;
            timer_d    = clamp_green(avg_of(avg_all, next_road_q));
          end
          PH_GREEN: begin
            phase_d     = PH_YELLOW;
            timer_d     = 8'(YELLOW_TIME);
            next_road_d = sel_next(cur_road_q, avg_all);
          end
          PH_YELLOW: begin
            phase_d = PH_ALLRED;
            timer_d = 8'(ALLRED_TIME);
          end
          default: begin
            phase_d = PH_ALLRED;
            timer_d = 8'(ALLRED_TIME);
          end
        endcase
      end
    end
    // Decoding from the next-state values keeps lights registered yet
    // aligned with phase_q/cur_road_q.
    lights_d = decode_lights(phase_d, cur_road_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= PH_ALLRED;
      timer_q     <= 8'(ALLRED_TIME);
      cur_road_q  <= 2'd3;
      next_road_q <= 2'd0;
      lights_q    <= ALL_RED;
    end else begin
      phase_q     <= phase_d;
      timer_q     <= timer_d;
      cur_road_q  <= cur_road_d;
      next_road_q <= next_road_d;
      lights_q    <= lights_d;
    end
  end

  assign next_road = next_road_q;
  assign cur_road  = cur_road_q;
  assign lights    = lights_q;
  assign phase     = phase_q;
  assign timer     = timer_q;

endmodule
